wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback logic for the 5-stage gshare RISC-V core.
- Captures the MEM-stage result and formats load data (LB/LH/LW/LBU/LHU).
- Selects the writeback source and drives the register-file write port (rd addr/data/wren), which also feeds the register file's WB->ID bypass.
- Keeps a retired-instruction counter.

---
 rtl/wb_stage_pkg.sv | 29 ++
 rtl/wb_stage_load_align.sv | 34 +++
 rtl/wb_stage.sv | 80 ++++++++
 tb/tb_wb_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared types for the MEM/WB writeback path: writeback source select,
// load funct3 encodings and the MEM/WB pipeline register layout.
package riscv_wb_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10,
      WB_RSVD = 2'b11
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rd_addr;
      logic        rd_wren;
      wb_sel_e     wb_sel;
      logic [31:0] alu_data;
      logic [31:0] ld_data;
      logic [2:0]  funct3;
   } memwb_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data formatter: extracts byte/halfword from an aligned word and extends it.
// Purely combinational; no state, no flow control.
module load_align
   import riscv_wb_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   output logic [31:0] ld_fmt
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      // offset[0] is ignored for halfwords; misaligned accesses trap upstream
      half_sel = offset[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_LB:   ld_fmt = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  ld_fmt = {24'd0, byte_sel};
         F3_LH:   ld_fmt = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  ld_fmt = {16'd0, half_sel};
         default: ld_fmt = word;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB register plus writeback mux, register-file write port and retire counter.
// One cycle MEM->WB; i_stall holds the entry, i_flush (dominant) inserts a bubble.
module wb_stage
   import riscv_wb_pkg::*;
#(
   parameter int          INSTRET_W = 64,
   parameter logic [31:0] RST_PC    = 32'h0000_0000
)(
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic                 i_mem_valid,
   input  logic [31:0]          i_mem_pc,
   input  logic [4:0]           i_mem_rd_addr,
   input  logic                 i_mem_rd_wren,
   input  logic [1:0]           i_mem_wb_sel,
   input  logic [31:0]          i_mem_alu_data,
   input  logic [31:0]          i_mem_ld_data,
   input  logic [2:0]           i_mem_funct3,
   output logic [4:0]           o_rd_addr,
   output logic [31:0]          o_rd_data,
   output logic                 o_rd_wren,
   output logic                 o_wb_valid,
   output logic [31:0]          o_wb_pc,
   output logic [INSTRET_W-1:0] o_instret
);

   memwb_t                q;
   logic [INSTRET_W-1:0]  instret_q;
   logic [31:0]           ld_fmt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         q         <= '0;
         q.pc      <= RST_PC;
         q.wb_sel  <= WB_ALU;
         instret_q <= '0;
      end else begin
         // Retirement counts the entry leaving WB, even if a flush hits the same edge
         if (q.valid && !i_stall)
            instret_q <= instret_q + INSTRET_W'(1);

         if (i_flush) begin
            q.valid <= 1'b0;
         end else if (!i_stall) begin
            q.valid    <= i_mem_valid;
            q.pc       <= i_mem_pc;
            q.rd_addr  <= i_mem_rd_addr;
            q.rd_wren  <= i_mem_rd_wren;
            q.wb_sel   <= wb_sel_e'(i_mem_wb_sel);
            q.alu_data <= i_mem_alu_data;
            q.ld_data  <= i_mem_ld_data;
            q.funct3   <= i_mem_funct3;
         end
      end
   end

   load_align u_load_align (
      .word   (q.ld_data),
      .funct3 (q.funct3),
      .offset (q.alu_data[1:0]),
      .ld_fmt (ld_fmt)
   );

   always_comb begin
      case (q.wb_sel)
         WB_LOAD: o_rd_data = ld_fmt;
         WB_PC4:  o_rd_data = q.pc + 32'd4;
         default: o_rd_data = q.alu_data;
      endcase
   end

   assign o_rd_addr  = q.rd_addr;
   assign o_rd_wren  = q.valid & q.rd_wren & (q.rd_addr != 5'd0);
   assign o_wb_valid = q.valid;
   assign o_wb_pc    = q.pc;
   assign o_instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/load/link writeback, stall/flush,
// x0 suppression and retire-counter wrap.
module tb_wb_stage;

   localparam logic [31:0] TB_RST_PC = 32'h0000_1000;

   logic        i_clk, i_reset, i_stall, i_flush;
   logic        i_mem_valid, i_mem_rd_wren;
   logic [31:0] i_mem_pc, i_mem_alu_data, i_mem_ld_data;
   logic [4:0]  i_mem_rd_addr;
   logic [1:0]  i_mem_wb_sel;
   logic [2:0]  i_mem_funct3;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;
   logic        o_rd_wren, o_wb_valid;
   logic [31:0] o_wb_pc;
   logic [63:0] o_instret;

   int          vec_cnt;
   int          err_cnt;
   logic        m_valid;
   logic [63:0] m_ret;

   wb_stage #(.INSTRET_W(64), .RST_PC(TB_RST_PC)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_stall        (i_stall),
      .i_flush        (i_flush),
      .i_mem_valid    (i_mem_valid),
      .i_mem_pc       (i_mem_pc),
      .i_mem_rd_addr  (i_mem_rd_addr),
      .i_mem_rd_wren  (i_mem_rd_wren),
      .i_mem_wb_sel   (i_mem_wb_sel),
      .i_mem_alu_data (i_mem_alu_data),
      .i_mem_ld_data  (i_mem_ld_data),
      .i_mem_funct3   (i_mem_funct3),
      .o_rd_addr      (o_rd_addr),
      .o_rd_data      (o_rd_data),
      .o_rd_wren      (o_rd_wren),
      .o_wb_valid     (o_wb_valid),
      .o_wb_pc        (o_wb_pc),
      .o_instret      (o_instret)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Advance one clock; track expected valid and retire count alongside
   task automatic tick;
      @(posedge i_clk);
      if (!i_reset) begin
         if (m_valid && !i_stall) m_ret = m_ret + 64'd1;
         if (i_flush) m_valid = 1'b0;
         else if (!i_stall) m_valid = i_mem_valid;
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                        input logic we, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [2:0] f3);
      i_mem_valid    = v;
      i_mem_pc       = pc;
      i_mem_rd_addr  = rd;
      i_mem_rd_wren  = we;
      i_mem_wb_sel   = sel;
      i_mem_alu_data = alu;
      i_mem_ld_data  = ld;
      i_mem_funct3   = f3;
   endtask

   task automatic bubble;
      drive(1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 3'b000);
   endtask

   task automatic test_reset;
      // Load something non-trivial, then assert reset between clock edges
      drive(1'b1, 32'h0000_0200, 5'd9, 1'b1, 2'b00, 32'hCAFE_F00D, 32'h0, 3'b010);
      tick();
      #3;
      i_reset = 1'b1;
      #1;
      vec_cnt++; if (o_wb_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %b exp 0", o_wb_valid); end
      vec_cnt++; if (o_rd_wren !== 1'b0) begin err_cnt++; $display("FAIL reset_wren got %b exp 0", o_rd_wren); end
      vec_cnt++; if (o_rd_addr !== 5'd0) begin err_cnt++; $display("FAIL reset_addr got %0d exp 0", o_rd_addr); end
      vec_cnt++; if (o_rd_data !== 32'd0) begin err_cnt++; $display("FAIL reset_data got %h exp 0", o_rd_data); end
      vec_cnt++; if (o_wb_pc !== TB_RST_PC) begin err_cnt++; $display("FAIL reset_pc got %h exp %h", o_wb_pc, TB_RST_PC); end
      vec_cnt++; if (o_instret !== 64'd0) begin err_cnt++; $display("FAIL reset_instret got %0d exp 0", o_instret); end
      m_valid = 1'b0;
      m_ret   = 64'd0;
      bubble();
      tick();
      #2;
      i_reset = 1'b0;
      tick();
   endtask

   task automatic test_alu;
      drive(1'b1, 32'h0000_0100, 5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 3'b000);
      tick();
      bubble();
      vec_cnt++; if (o_rd_wren !== 1'b1) begin err_cnt++; $display("FAIL alu_wren got %b exp 1", o_rd_wren); end
      vec_cnt++; if (o_rd_addr !== 5'd5) begin err_cnt++; $display("FAIL alu_addr got %0d exp 5", o_rd_addr); end
      vec_cnt++; if (o_rd_data !== 32'h1234_5678) begin err_cnt++; $display("FAIL alu_data got %h exp 12345678", o_rd_data); end
      vec_cnt++; if (o_wb_pc !== 32'h0000_0100) begin err_cnt++; $display("FAIL alu_pc got %h exp 00000100", o_wb_pc); end
      vec_cnt++; if (o_instret !== 64'd0) begin err_cnt++; $display("FAIL alu_instret_pre got %0d exp 0", o_instret); end
      tick();
      vec_cnt++; if (o_instret !== 64'd1) begin err_cnt++; $display("FAIL alu_instret_post got %0d exp 1", o_instret); end
      vec_cnt++; if (o_wb_valid !== 1'b0) begin err_cnt++; $display("FAIL alu_bubble_valid got %b exp 0", o_wb_valid); end
   endtask

   task automatic test_load;
      logic [2:0]  f3_t  [8] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011};
      logic [1:0]  off_t [8] = '{2'd0,   2'd2,   2'd3,   2'd2,   2'd0,   2'd3,   2'd3,   2'd1};
      logic [31:0] exp_t [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h80FF_7F01, 32'hFFFF_80FF, 32'h80FF_7F01};
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h0000_0300 + 32'(i * 4), 5'd10, 1'b1, 2'b01,
               {30'h0800_0000, off_t[i]}, 32'h80FF_7F01, f3_t[i]);
         tick();
         vec_cnt++;
         if (o_rd_data !== exp_t[i]) begin
            err_cnt++;
            $display("FAIL load_%0d f3=%b off=%0d got %h exp %h", i, f3_t[i], off_t[i], o_rd_data, exp_t[i]);
         end
      end
      bubble();
      tick();
      vec_cnt++; if (o_instret !== m_ret) begin err_cnt++; $display("FAIL load_instret got %0d exp %0d", o_instret, m_ret); end
   endtask

   task automatic test_jal;
      drive(1'b1, 32'hFFFF_FFFC, 5'd1, 1'b1, 2'b10, 32'hDEAD_BEEF, 32'h0, 3'b000);
      tick();
      vec_cnt++; if (o_rd_data !== 32'h0000_0000) begin err_cnt++; $display("FAIL jal_wrap got %h exp 00000000", o_rd_data); end
      drive(1'b1, 32'h0000_0100, 5'd1, 1'b1, 2'b10, 32'hDEAD_BEEF, 32'h0, 3'b000);
      tick();
      vec_cnt++; if (o_rd_data !== 32'h0000_0104) begin err_cnt++; $display("FAIL jal_link got %h exp 00000104", o_rd_data); end
      drive(1'b1, 32'h0000_0100, 5'd2, 1'b1, 2'b11, 32'h0BAD_F00D, 32'h1111_1111, 3'b000);
      tick();
      vec_cnt++; if (o_rd_data !== 32'h0BAD_F00D) begin err_cnt++; $display("FAIL sel_rsvd got %h exp 0badf00d", o_rd_data); end
      bubble();
      tick();
   endtask

   task automatic test_stall_flush;
      logic [63:0] ret_hold;
      drive(1'b1, 32'h0000_0400, 5'd7, 1'b1, 2'b00, 32'hA5A5_A5A5, 32'h0, 3'b000);
      tick();
      i_stall  = 1'b1;
      ret_hold = m_ret;
      drive(1'b1, 32'h0000_0500, 5'd8, 1'b1, 2'b00, 32'h5A5A_5A5A, 32'h0, 3'b000);
      for (int c = 0; c < 3; c++) begin
         tick();
         vec_cnt++;
         if (o_rd_data !== 32'hA5A5_A5A5 || o_rd_addr !== 5'd7 || o_rd_wren !== 1'b1 || o_wb_pc !== 32'h0000_0400) begin
            err_cnt++;
            $display("FAIL stall_hold_%0d got data=%h addr=%0d wren=%b pc=%h exp a5a5a5a5/7/1/00000400", c, o_rd_data, o_rd_addr, o_rd_wren, o_wb_pc);
         end
         vec_cnt++; if (o_instret !== ret_hold) begin err_cnt++; $display("FAIL stall_instret_%0d got %0d exp %0d", c, o_instret, ret_hold); end
      end
      i_flush = 1'b1;
      tick();
      vec_cnt++; if (o_wb_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_valid got %b exp 0", o_wb_valid); end
      vec_cnt++; if (o_rd_wren !== 1'b0) begin err_cnt++; $display("FAIL flush_wren got %b exp 0", o_rd_wren); end
      vec_cnt++; if (o_instret !== ret_hold) begin err_cnt++; $display("FAIL flush_stall_instret got %0d exp %0d", o_instret, ret_hold); end
      i_flush = 1'b0;
      i_stall = 1'b0;
      bubble();
      tick();
   endtask

   task automatic test_x0;
      logic [63:0] ret_before;
      ret_before = m_ret;
      drive(1'b1, 32'h0000_0600, 5'd0, 1'b1, 2'b01, 32'h0000_0000, 32'h1234_5678, 3'b010);
      tick();
      vec_cnt++; if (o_rd_wren !== 1'b0) begin err_cnt++; $display("FAIL x0_wren got %b exp 0", o_rd_wren); end
      vec_cnt++; if (o_wb_valid !== 1'b1) begin err_cnt++; $display("FAIL x0_valid got %b exp 1", o_wb_valid); end
      // Flush on the retiring edge must not drop the retirement
      i_flush = 1'b1;
      bubble();
      tick();
      i_flush = 1'b0;
      vec_cnt++; if (o_instret !== ret_before + 64'd1) begin err_cnt++; $display("FAIL x0_instret got %0d exp %0d", o_instret, ret_before + 64'd1); end
   endtask

   task automatic test_wrap;
      drive(1'b1, 32'h0000_0700, 5'd3, 1'b1, 2'b00, 32'h0000_0033, 32'h0, 3'b000);
      tick();
      bubble();
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      m_ret = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      vec_cnt++; if (o_instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin err_cnt++; $display("FAIL wrap_preload got %h exp ffffffffffffffff", o_instret); end
      tick();
      vec_cnt++; if (o_instret !== 64'd0) begin err_cnt++; $display("FAIL wrap_instret got %h exp 0", o_instret); end
   endtask

   task automatic test_reset_mid_stall;
      drive(1'b1, 32'h0000_0800, 5'd4, 1'b1, 2'b00, 32'h0000_0044, 32'h0, 3'b000);
      tick();
      tick();
      i_stall = 1'b1;
      i_flush = 1'b1;
      #2;
      i_reset = 1'b1;
      #1;
      vec_cnt++; if (o_instret !== 64'd0 || o_wb_valid !== 1'b0 || o_wb_pc !== TB_RST_PC) begin
         err_cnt++;
         $display("FAIL reset_mid_stall got ret=%0d valid=%b pc=%h exp 0/0/%h", o_instret, o_wb_valid, o_wb_pc, TB_RST_PC);
      end
      m_valid = 1'b0;
      m_ret   = 64'd0;
      i_stall = 1'b0;
      i_flush = 1'b0;
      bubble();
      tick();
      i_reset = 1'b0;
      tick();
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      m_valid = 1'b0;
      m_ret   = 64'd0;
      i_reset = 1'b1;
      i_stall = 1'b0;
      i_flush = 1'b0;
      bubble();
      #12;
      i_reset = 1'b0;
      tick();
      test_reset();
      test_alu();
      test_load();
      test_jal();
      test_stall_flush();
      test_x0();
      test_wrap();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
